// File: rtl/data_memory_pkg.sv
// Shared load/store codes and the default storage size for the RV32I data memory.
package data_memory_pkg;
  localparam int DMEM_DEPTH_BYTES = 1024;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;
endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the core and the data memory; misaligned exists only with DMEM_MISALIGN_CHECK_EN.
interface data_memory_if;
  logic [2:0]  MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] Address;
  logic [31:0] dataToMem;
  logic [31:0] data;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  modport master (
    output MemRead, MemWrite, Address, dataToMem,
    input  data
`ifdef DMEM_MISALIGN_CHECK_EN
    , input misaligned
`endif
  );

  modport slave (
    input  MemRead, MemWrite, Address, dataToMem,
    output data
`ifdef DMEM_MISALIGN_CHECK_EN
    , output misaligned
`endif
  );
endinterface

// File: rtl/data_memory_load_extend.sv
// Selects and sign/zero-extends the load result from the 4 little-endian bytes at idx.
// Purely combinational, zero latency; no flow control.
module load_extend
  import data_memory_pkg::*;
(
  input  logic [2:0]  mem_read,
  input  logic [31:0] raw,
  output logic [31:0] ext
);
  always_comb begin
    ext = 32'h0;
    case (mem_read)
      LD_B:    ext = {{24{raw[7]}}, raw[7:0]};
      LD_BU:   ext = {24'h0, raw[7:0]};
      LD_H:    ext = {{16{raw[15]}}, raw[15:0]};
      LD_HU:   ext = {16'h0, raw[15:0]};
      LD_W:    ext = raw;
      LD_NONE: ext = 32'h0;
      default: ext = 32'h0;
    endcase
  end
endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian RV32I data memory: combinational loads, stores commit on clk rise, wraps at top.
// No backpressure; optional DMEM_MISALIGN_CHECK_EN flags and suppresses misaligned halfword/word accesses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input logic          clk,
  input logic          rstn,
  data_memory_if.slave bus
);
  logic [7:0]        mem_q [DEPTH_BYTES];
  logic [7:0]        mem_d [DEPTH_BYTES];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] lane_idx [4];
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic [3:0]        wr_mask;
  logic              ld_mis;
  logic              st_mis;
  logic              unused_addr_hi;

  assign idx            = bus.Address[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.Address[31:ADDR_W];

  // Each lane index wraps modulo DEPTH_BYTES through the ADDR_W-bit add.
  always_comb begin
    raw = 32'h0;
    for (int k = 0; k < 4; k++) begin
      lane_idx[k]     = idx + ADDR_W'(k);
      raw[8*k +: 8]   = mem_q[lane_idx[k]];
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign ld_mis = (((bus.MemRead == LD_H) || (bus.MemRead == LD_HU)) && bus.Address[0]) ||
                  ((bus.MemRead == LD_W) && (bus.Address[1:0] != 2'b00));
  assign st_mis = ((bus.MemWrite == ST_H) && bus.Address[0]) ||
                  ((bus.MemWrite == ST_W) && (bus.Address[1:0] != 2'b00));
  assign bus.misaligned = rstn && (ld_mis || st_mis);
`else
  assign ld_mis = 1'b0;
  assign st_mis = 1'b0;
`endif

  load_extend u_load_extend (
    .mem_read (bus.MemRead),
    .raw      (raw),
    .ext      (ext)
  );

  assign bus.data = (rstn && !ld_mis) ? ext : 32'h0;

  always_comb begin
    wr_mask = 4'b0000;
    case (bus.MemWrite)
      ST_B:    wr_mask = 4'b0001;
      ST_H:    wr_mask = 4'b0011;
      ST_W:    wr_mask = 4'b1111;
      ST_NONE: wr_mask = 4'b0000;
      default: wr_mask = 4'b0000;
    endcase
    if (st_mis) wr_mask = 4'b0000;
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_mask[k]) mem_d[lane_idx[k]] = bus.dataToMem[8*k +: 8];
    end
  end

  // Reset wins over any store presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) mem_q <= '{default: 8'h00};
    else       mem_q <= mem_d;
  end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed cases then random traffic against a byte-array reference model.
module tb_data_memory;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  data_memory_if bus ();

  data_memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [DEPTH];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;
  bit         stim_done = 1'b0;

  function automatic bit is_load(input logic [2:0] rd);
    return (rd >= 3'd1) && (rd <= 3'd5);
  endfunction

  function automatic bit ref_mis(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    bit h_odd = (a % 2) != 0;
    bit w_off = (a % 4) != 0;
    return ((rd == 3'd2 || rd == 3'd5 || wr == 2'd2) && h_odd) || ((rd == 3'd3 || wr == 2'd3) && w_off);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ref_ld_mis(input logic [2:0] rd, input logic [31:0] a);
    return ref_mis(rd, 2'd0, a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] rd, input logic [31:0] a);
    int unsigned base = a % DEPTH;
    longint b0 = ref_mem[base];
    longint h  = b0 + 256 * longint'(ref_mem[(base + 1) % DEPTH]);
    longint w  = h + 65536 * longint'(ref_mem[(base + 2) % DEPTH])
                   + 16777216 * longint'(ref_mem[(base + 3) % DEPTH]);
    longint v;
    case (rd)
      3'd1:    v = (b0 > 127) ? b0 - 256 : b0;
      3'd2:    v = (h > 32767) ? h - 65536 : h;
      3'd3:    v = w;
      3'd4:    v = b0;
      3'd5:    v = h;
      default: v = 0;
    endcase
    if (ref_ld_mis(rd, a)) v = 0;
    return 32'(v);
  endfunction

  function automatic void ref_store(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
    int n = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : (wr == 2'd3) ? 4 : 0;
    if (ref_mis(3'd0, wr, a)) n = 0;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % DEPTH] = 8'((wd >> (8 * i)) & 32'hFF);
  endfunction

  // Drive one cycle; exp is the expected load response (pushed only for load codes), then commit the model.
  task automatic drive(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, input exp_t exp);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = a;
    bus.dataToMem = wd;
    if (is_load(rd)) exp_q.push_back(exp);
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    end else begin
      ref_store(wr, a, wd);
    end
    #1;
  endtask

  task automatic op_model(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.d = rstn ? ref_load(rd, a) : 32'h0;
    e.m = rstn && ref_mis(rd, wr, a);
    drive(rd, wr, a, wd, e);
  endtask

  task automatic op_const(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] d, input logic m);
    exp_t e;
    e.d = d;
    e.m = m;
    drive(rd, wr, a, wd, e);
  endtask

  always @(negedge clk) begin
    if (is_load(bus.MemRead)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation addr=%h data=%h", bus.Address, bus.data);
      end else begin
        e = exp_q.pop_front();
        if (bus.data !== e.d) begin
          errors++;
          $display("FAIL load_data rd=%0d addr=%h got=%h want=%h", bus.MemRead, bus.Address, bus.data, e.d);
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        checks++;
        if (bus.misaligned !== e.m) begin
          errors++;
          $display("FAIL misaligned rd=%0d wr=%0d addr=%h got=%b want=%b",
                   bus.MemRead, bus.MemWrite, bus.Address, bus.misaligned, e.m);
        end
`endif
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    bus.MemRead = 3'd0; bus.MemWrite = 2'd0; bus.Address = 32'h0; bus.dataToMem = 32'h0;
    rstn = 1'b0;
    @(posedge clk); #1;

    // Reset: load forced to zero, store discarded.
    op_const(3'd3, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    op_const(3'd3, 2'd3, 32'h4, 32'h12345678, 32'h0, 1'b0);
    rstn = 1'b1;
    op_const(3'd3, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    op_const(3'd3, 2'd0, 32'h4, 32'h0, 32'h0, 1'b0);

    // Word store then every load width.
    op_const(3'd0, 2'd3, 32'h10, 32'h80F1A2B3, 32'h0, 1'b0);
    op_const(3'd3, 2'd0, 32'h10, 32'h0, 32'h80F1A2B3, 1'b0);
    op_const(3'd1, 2'd0, 32'h10, 32'h0, 32'hFFFFFFB3, 1'b0);
    op_const(3'd4, 2'd0, 32'h13, 32'h0, 32'h00000080, 1'b0);
    op_const(3'd2, 2'd0, 32'h12, 32'h0, 32'hFFFF80F1, 1'b0);
    op_const(3'd5, 2'd0, 32'h12, 32'h0, 32'h000080F1, 1'b0);

    // Partial stores, then same-cycle read sees pre-edge contents.
    op_const(3'd0, 2'd1, 32'h11, 32'h00000055, 32'h0, 1'b0);
    op_const(3'd0, 2'd2, 32'h12, 32'h00007E01, 32'h0, 1'b0);
    op_const(3'd3, 2'd0, 32'h10, 32'h0, 32'h7E0155B3, 1'b0);
    op_const(3'd3, 2'd3, 32'h10, 32'hDEADBEEF, 32'h7E0155B3, 1'b0);
    op_const(3'd3, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    op_const(3'd6, 2'd0, 32'h10, 32'h0, 32'h0, 1'b0);

`ifndef DMEM_MISALIGN_CHECK_EN
    // Wrap at the top of memory and address aliasing.
    op_const(3'd0, 2'd3, 32'h3FE, 32'hAABBCCDD, 32'h0, 1'b0);
    op_const(3'd4, 2'd0, 32'h3FF, 32'h0, 32'h000000CC, 1'b0);
    op_const(3'd5, 2'd0, 32'h0, 32'h0, 32'h0000AABB, 1'b0);
    op_const(3'd3, 2'd0, 32'h3FE, 32'h0, 32'hAABBCCDD, 1'b0);
`endif
    op_const(3'd0, 2'd1, 32'h400, 32'h00000011, 32'h0, 1'b0);
    op_const(3'd4, 2'd0, 32'h0, 32'h0, 32'h00000011, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
    op_const(3'd3, 2'd3, 32'h21, 32'hCAFEBABE, 32'h0, 1'b1);
    op_const(3'd3, 2'd0, 32'h20, 32'h0, 32'h0, 1'b0);
    op_const(3'd3, 2'd0, 32'h24, 32'h0, 32'h0, 1'b0);
    op_const(3'd0, 2'd3, 32'h24, 32'h11223344, 32'h0, 1'b0);
    op_const(3'd2, 2'd0, 32'h23, 32'h0, 32'h0, 1'b1);
    op_const(3'd5, 2'd0, 32'h24, 32'h0, 32'h00003344, 1'b0);
`endif

    // Random traffic over a small window (with aliased upper bits) plus the wrap region.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [2:0]  rd;
      logic [1:0]  wr;
      a  = ($urandom & 32'hFFFF_FC00) |
           (($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, 47));
      rd = 3'($urandom_range(0, 7));
      wr = 2'($urandom_range(0, 3));
      op_model(rd, wr, a, $urandom);
      if (n == 1500) begin
        rstn = 1'b0;
        op_model(3'd3, 2'd3, 32'h8, 32'hFFFFFFFF);
        rstn = 1'b1;
        op_model(3'd3, 2'd0, 32'h8, 32'h0);
      end
    end

    bus.MemRead = 3'd0; bus.MemWrite = 2'd0;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
